// File: rtl/sd_data_rx.sv
// sd_data_rx: receive-side SD DAT[3:0] engine.
// Waits for a start bit, deserialises one block in 1-bit or 4-bit mode,
// pushes nibbles into the RX FIFO, checks per-line CRC16 and the end bit.
// Optional build macro: SD_RX_TIMEOUT_EN (start-bit timeout counter).
//
// state        | meaning
// -------------+-------------------------------------------------------
// S_IDLE       | waiting for start_rx
// S_WAIT_START | armed, looking for the start bit (optionally timed)
// S_DATA       | sampling data nibbles/bits, updating the CRCs
// S_CRC        | shifting in 16 received CRC bits per active line
// S_END        | sampling the end bit, latching crc_ok
// S_DONE       | one-cycle done pulse
module sd_data_rx #(
  parameter int BLK_LEN_W = 12,
  parameter int TIMEOUT_W = 16
) (
  input  logic                 sd_clk,
  input  logic                 rst,
  input  logic [3:0]           dat_i,
  input  logic                 bus_4bit,
  input  logic [BLK_LEN_W-1:0] blk_len,
  input  logic [TIMEOUT_W-1:0] timeout,
  input  logic                 start_rx,
  input  logic                 abort,
  input  logic                 fifo_full,
  output logic [3:0]           fifo_d,
  output logic                 fifo_wr,
  output logic                 busy,
  output logic                 done,
  output logic                 crc_ok,
  output logic                 ovf,
  output logic                 tout
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_START = 3'd1,
    S_DATA       = 3'd2,
    S_CRC        = 3'd3,
    S_END        = 3'd4,
    S_DONE       = 3'd5
  } state_t;

  localparam logic [15:0]        CRC_POLY = 16'h1021;
  localparam logic [BLK_LEN_W:0] NIB_ONE  = 1;
  localparam logic [BLK_LEN_W:0] NIB_TWO  = 2;

  state_t state_q, state_d;

  logic                 bus4_q, bus4_d;
  logic [BLK_LEN_W:0]   nib_cnt_q, nib_cnt_d;
  logic [1:0]           bit_cnt_q, bit_cnt_d;
  logic [3:0]           crc_cnt_q, crc_cnt_d;
  logic [2:0]           sh_q, sh_d;
  logic [3:0][15:0]     crc_q, crc_d;
  logic [3:0][15:0]     rx_crc_q, rx_crc_d;
  logic [3:0]           fifo_d_q, fifo_d_d;
  logic                 fifo_wr_q, fifo_wr_d;
  logic                 crc_ok_q, crc_ok_d;
  logic                 ovf_q, ovf_d;
  logic                 tout_q, tout_d;

  logic [3:0]           line_en;
  logic [3:0]           crc_match;
  logic                 start_bit;
  logic                 end_ok;
  logic                 nib_done;
  logic                 last_nib;
  logic                 tmo_hit;

  // In 1-bit mode only DAT0 carries data, CRC and end bit.
  assign line_en   = bus4_q ? 4'hF : 4'h1;
  assign start_bit = bus4_q ? (dat_i == 4'h0) : ~dat_i[0];
  assign end_ok    = &(dat_i | ~line_en);
  assign nib_done  = (state_q == S_DATA) && (bus4_q || (bit_cnt_q == 2'd3));
  assign last_nib  = nib_done && (nib_cnt_q == NIB_ONE);

`ifdef SD_RX_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] TMR_ONE = 1;
  logic [TIMEOUT_W-1:0] tmr_q, tmr_d;

  // Timeout fires on the cycle the counter would reach zero (or already is zero)
  assign tmo_hit = (state_q == S_WAIT_START) && !start_bit && (tmr_q <= TMR_ONE);

  // Start-bit timer: load on arm, count down while waiting for the start bit
  always_comb begin
    tmr_d = tmr_q;
    if (!abort) begin
      if (state_q == S_IDLE && start_rx) begin
        tmr_d = timeout;
      end else if (state_q == S_WAIT_START && tmr_q != '0) begin
        tmr_d = tmr_q - 1'b1;
      end
    end
  end

  // Start-bit timer register
  always_ff @(posedge sd_clk or posedge rst) begin
    if (rst) tmr_q <= '0;
    else     tmr_q <= tmr_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^timeout;
  assign tmo_hit        = 1'b0;
`endif

  // Per-line CRC comparison, inactive lines always match
  always_comb begin
    crc_match = 4'hF;
    for (int i = 0; i < 4; i++) begin
      if (line_en[i] && (crc_q[i] != rx_crc_q[i])) crc_match[i] = 1'b0;
    end
  end

  // State register
  always_ff @(posedge sd_clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; abort wins over everything
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:       if (start_rx) state_d = S_WAIT_START;
        S_WAIT_START: begin
          if (start_bit)    state_d = S_DATA;
          else if (tmo_hit) state_d = S_DONE;
        end
        S_DATA:       if (last_nib) state_d = S_CRC;
        S_CRC:        if (crc_cnt_q == 4'd0) state_d = S_END;
        S_END:        state_d = S_DONE;
        S_DONE:       state_d = S_IDLE;
        default:      state_d = S_IDLE;
      endcase
    end
  end

  // State-decoded outputs
  always_comb begin
    busy = (state_q != S_IDLE);
    done = (state_q == S_DONE);
  end

  // Datapath next values: deserialiser, counters, CRCs, status
  always_comb begin
    bus4_d    = bus4_q;
    nib_cnt_d = nib_cnt_q;
    bit_cnt_d = bit_cnt_q;
    crc_cnt_d = crc_cnt_q;
    sh_d      = sh_q;
    crc_d     = crc_q;
    rx_crc_d  = rx_crc_q;
    fifo_d_d  = fifo_d_q;
    fifo_wr_d = 1'b0;
    crc_ok_d  = crc_ok_q;
    ovf_d     = ovf_q;
    tout_d    = tout_q;
    if (!abort) begin
      case (state_q)
        S_IDLE: begin
          if (start_rx) begin
            bus4_d    = bus_4bit;
            nib_cnt_d = (blk_len == '0) ? NIB_TWO : {blk_len, 1'b0};
            bit_cnt_d = '0;
            sh_d      = '0;
            crc_d     = '0;
            rx_crc_d  = '0;
            crc_ok_d  = 1'b0;
            ovf_d     = 1'b0;
            tout_d    = 1'b0;
          end
        end
        S_WAIT_START: begin
          if (tmo_hit) begin
            tout_d   = 1'b1;
            crc_ok_d = 1'b0;
          end
        end
        S_DATA: begin
          for (int i = 0; i < 4; i++) begin
            if (line_en[i]) begin
              crc_d[i] = {crc_q[i][14:0], 1'b0} ^
                         ((crc_q[i][15] ^ dat_i[i]) ? CRC_POLY : 16'h0000);
            end
          end
          sh_d      = {sh_q[1:0], dat_i[0]};
          bit_cnt_d = bit_cnt_q + 2'd1;
          if (nib_done) begin
            nib_cnt_d = nib_cnt_q - 1'b1;
            if (fifo_full) begin
              ovf_d = 1'b1;
            end else begin
              fifo_wr_d = 1'b1;
              fifo_d_d  = bus4_q ? dat_i : {sh_q, dat_i[0]};
            end
          end
          if (last_nib) crc_cnt_d = 4'd15;
        end
        S_CRC: begin
          for (int i = 0; i < 4; i++) begin
            rx_crc_d[i] = {rx_crc_q[i][14:0], dat_i[i]};
          end
          crc_cnt_d = crc_cnt_q - 1'b1;
        end
        S_END: begin
          crc_ok_d = end_ok && (&crc_match);
        end
        default: ;
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge sd_clk or posedge rst) begin
    if (rst) begin
      bus4_q    <= 1'b0;
      nib_cnt_q <= '0;
      bit_cnt_q <= '0;
      crc_cnt_q <= '0;
      sh_q      <= '0;
      crc_q     <= '0;
      rx_crc_q  <= '0;
      fifo_d_q  <= '0;
      fifo_wr_q <= 1'b0;
      crc_ok_q  <= 1'b0;
      ovf_q     <= 1'b0;
      tout_q    <= 1'b0;
    end else begin
      bus4_q    <= bus4_d;
      nib_cnt_q <= nib_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      crc_cnt_q <= crc_cnt_d;
      sh_q      <= sh_d;
      crc_q     <= crc_d;
      rx_crc_q  <= rx_crc_d;
      fifo_d_q  <= fifo_d_d;
      fifo_wr_q <= fifo_wr_d;
      crc_ok_q  <= crc_ok_d;
      ovf_q     <= ovf_d;
      tout_q    <= tout_d;
    end
  end

  assign fifo_d  = fifo_d_q;
  assign fifo_wr = fifo_wr_q;
  assign crc_ok  = crc_ok_q;
  assign ovf     = ovf_q;
  assign tout    = tout_q;

endmodule

// File: tb/tb_sd_data_rx.sv
// Bench for sd_data_rx: table of directed blocks, randomized blocks against a
// message-level CRC/nibble model, plus abort, async reset and timeout sequences.
`timescale 1ns/1ps
module tb_sd_data_rx;

  logic        sd_clk = 1'b0;
  logic        rst;
  logic [3:0]  dat_i;
  logic        bus_4bit;
  logic [11:0] blk_len;
  logic [15:0] timeout;
  logic        start_rx, abort, fifo_full;
  logic [3:0]  fifo_d;
  logic        fifo_wr, busy, done, crc_ok, ovf, tout;

  sd_data_rx #(.BLK_LEN_W(12), .TIMEOUT_W(16)) dut (
    .sd_clk(sd_clk), .rst(rst), .dat_i(dat_i), .bus_4bit(bus_4bit),
    .blk_len(blk_len), .timeout(timeout), .start_rx(start_rx), .abort(abort),
    .fifo_full(fifo_full), .fifo_d(fifo_d), .fifo_wr(fifo_wr), .busy(busy),
    .done(done), .crc_ok(crc_ok), .ovf(ovf), .tout(tout)
  );

  always #5 sd_clk = ~sd_clk;

  typedef struct {
    logic        bus4;
    logic [11:0] blen;
    logic [31:0] bytes;
    logic        flip_en;
    int          flip_line;
    int          flip_bit;
    logic [3:0]  endv;
    int          full_lo;
    int          full_hi;
    logic        exp_crc;
    logic        exp_ovf;
    int          exp_nwr;
  } vec_t;

  vec_t        tbl[11];
  int          total = 0, bad = 0, cyc = 0;
  int          done_cnt, done_cyc, cs;
  logic        done_crc;
  logic [3:0]  wr_val[$];
  int          wr_cyc[$];
  logic [3:0]  dq[$];
  logic [7:0]  blk_bytes[64];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  task automatic clear_obs();
    wr_val.delete();
    wr_cyc.delete();
    done_cnt = 0;
    done_cyc = -1;
    done_crc = 1'bx;
  endtask

  // one clock: outputs are observed 1ns after the edge, inputs change there too
  task automatic cycle();
    @(posedge sd_clk);
    #1;
    cyc++;
    if (fifo_wr === 1'b1) begin
      wr_val.push_back(fifo_d);
      wr_cyc.push_back(cyc);
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
      done_crc = crc_ok;
    end
  endtask

  // CRC16 (x^16+x^12+x^5+1, init 0) of one line as polynomial remainder of M(x)*x^16
  function automatic logic [15:0] line_crc(input int ln);
    logic [16:0] r;
    r = '0;
    for (int k = 0; k < dq.size() + 16; k++) begin
      r = {r[15:0], (k < dq.size()) ? dq[k][ln] : 1'b0};
      if (r[16]) r = r ^ 17'h11021;
    end
    return r[15:0];
  endfunction

  task automatic run_block(input string nm, input logic bus4, input logic [11:0] blen,
                           input logic flip_en, input int flip_line, input int flip_bit,
                           input logic [3:0] endv, input int full_lo, input int full_hi,
                           input logic exp_crc, input logic exp_ovf, input int exp_nwr);
    int          nb, nnib, d, s, j;
    logic [15:0] tx[4];
    logic [3:0]  v;
    logic [3:0]  ev[$];
    int          ec[$];
    nb   = (blen == 12'd0) ? 1 : int'(blen);
    nnib = 2 * nb;
    d    = bus4 ? nnib : 8 * nb;
    dq.delete();
    for (int k = 0; k < d; k++) begin
      if (bus4) v = (k % 2 == 0) ? blk_bytes[k/2][7:4] : blk_bytes[k/2][3:0];
      else      v = (4'($urandom) & 4'hE) | {3'b000, blk_bytes[k/8][7 - (k % 8)]};
      dq.push_back(v);
    end
    for (int i = 0; i < 4; i++) begin
      tx[i] = line_crc(i);
      if (flip_en && flip_line == i) tx[i][flip_bit] = ~tx[i][flip_bit];
    end
    for (int n = 0; n < nnib; n++) begin
      if (!(n >= full_lo && n <= full_hi)) begin
        ev.push_back((n % 2 == 0) ? blk_bytes[n/2][7:4] : blk_bytes[n/2][3:0]);
        ec.push_back(bus4 ? n + 1 : 4 * n + 4);
      end
    end

    abort = 1'b0; fifo_full = 1'b0;
    bus_4bit = bus4; blk_len = blen; start_rx = 1'b1; dat_i = 4'hF;
    cycle();
    start_rx = 1'b0; bus_4bit = ~bus4; blk_len = 12'($urandom);
    chk({nm, "/armed"}, {busy, crc_ok, ovf, tout}, 4'b1000);
    clear_obs();
    repeat ($urandom_range(0, 3)) begin
      dat_i = bus4 ? 4'hF : (4'($urandom) | 4'h1);
      cycle();
    end
    dat_i = bus4 ? 4'h0 : (4'($urandom) & 4'hE);
    cycle();
    s = cyc;
    for (int k = 0; k < d; k++) begin
      dat_i = dq[k];
      if (bus4)             j = k;
      else if (k % 4 == 3)  j = k / 4;
      else                  j = -1;
      fifo_full = (j >= 0) ? (j >= full_lo && j <= full_hi) : 1'($urandom);
      cycle();
    end
    fifo_full = 1'b0;
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < 4; i++) v[i] = tx[i][15 - k];
      dat_i = bus4 ? v : ((4'($urandom) & 4'hE) | {3'b000, v[0]});
      cycle();
    end
    dat_i = bus4 ? endv : ((4'($urandom) & 4'hE) | {3'b000, endv[0]});
    cycle();
    dat_i = 4'hF;
    cycle();
    cycle();

    chk({nm, "/done_cnt"}, done_cnt, 1);
    chk({nm, "/done_lat"}, done_cyc - s, d + 17);
    chk({nm, "/crc_ok"}, done_crc, exp_crc);
    chk({nm, "/crc_ok_hold"}, crc_ok, exp_crc);
    chk({nm, "/ovf"}, ovf, exp_ovf);
    chk({nm, "/busy_after"}, busy, 1'b0);
    chk({nm, "/nwr"}, wr_val.size(), exp_nwr);
    for (int n = 0; n < wr_val.size() && n < ev.size(); n++) begin
      chk({nm, "/nib_cyc_val"}, ((wr_cyc[n] - s) << 4) | int'(wr_val[n]), (ec[n] << 4) | int'(ev[n]));
    end
  endtask

  initial begin
    vec_t        t;
    logic        rb4, rfe, ecrc;
    logic [11:0] rbl;
    logic [3:0]  rev;
    int          rfl, rfb, lo, hi, cnt;

    rst = 1'b1; dat_i = 4'hF; bus_4bit = 1'b0; blk_len = '0; timeout = 16'hFFFF;
    start_rx = 1'b0; abort = 1'b0; fifo_full = 1'b0;
    clear_obs();

    //            bus4  blen    bytes          flip ln bit endv  lo hi  crc  ovf  nwr
    tbl[0]  = '{1'b1, 12'd4, 32'h12345678, 1'b0, 0, 0,  4'hF, 1, 0, 1'b1, 1'b0, 8};
    tbl[1]  = '{1'b0, 12'd2, 32'hA53C0000, 1'b0, 0, 0,  4'hF, 1, 0, 1'b1, 1'b0, 4};
    tbl[2]  = '{1'b1, 12'd4, 32'h12345678, 1'b1, 2, 5,  4'hF, 1, 0, 1'b0, 1'b0, 8};
    tbl[3]  = '{1'b1, 12'd4, 32'h12345678, 1'b0, 0, 0,  4'hE, 1, 0, 1'b0, 1'b0, 8};
    tbl[4]  = '{1'b1, 12'd4, 32'h12345678, 1'b0, 0, 0,  4'hF, 2, 3, 1'b1, 1'b1, 6};
    tbl[5]  = '{1'b0, 12'd2, 32'hA53C0000, 1'b0, 0, 0,  4'hE, 1, 0, 1'b0, 1'b0, 4};
    tbl[6]  = '{1'b0, 12'd2, 32'hA53C0000, 1'b1, 0, 15, 4'hF, 1, 0, 1'b0, 1'b0, 4};
    tbl[7]  = '{1'b1, 12'd4, 32'h12345678, 1'b0, 0, 0,  4'h7, 1, 0, 1'b0, 1'b0, 8};
    tbl[8]  = '{1'b1, 12'd0, 32'h9C000000, 1'b0, 0, 0,  4'hF, 1, 0, 1'b1, 1'b0, 2};
    tbl[9]  = '{1'b0, 12'd2, 32'hA53C0000, 1'b1, 3, 4,  4'hF, 1, 0, 1'b1, 1'b0, 4};
    tbl[10] = '{1'b0, 12'd1, 32'h5A000000, 1'b0, 0, 0,  4'hF, 1, 1, 1'b1, 1'b1, 1};

    #12;
    chk("reset_outs", {fifo_d, fifo_wr, busy, done, crc_ok, ovf, tout}, 0);
    @(negedge sd_clk);
    rst = 1'b0;
    cycle();
    cycle();
    chk("idle_outs", {fifo_d, fifo_wr, busy, done, crc_ok, ovf, tout}, 0);

    for (int r = 0; r < 11; r++) begin
      t = tbl[r];
      for (int k = 0; k < 4; k++) blk_bytes[k] = t.bytes[31 - 8*k -: 8];
      run_block($sformatf("tbl%0d", r), t.bus4, t.blen, t.flip_en, t.flip_line, t.flip_bit,
                t.endv, t.full_lo, t.full_hi, t.exp_crc, t.exp_ovf, t.exp_nwr);
    end

    // abort at the third nibble of a 512-byte block
    bus_4bit = 1'b1; blk_len = 12'd512; start_rx = 1'b1; dat_i = 4'hF;
    cycle();
    start_rx = 1'b0;
    clear_obs();
    dat_i = 4'h0; cycle();
    dat_i = 4'h1; cycle();
    dat_i = 4'h2; cycle();
    chk("abort/pre_busy", busy, 1'b1);
    dat_i = 4'h3; abort = 1'b1;
    cycle();
    abort = 1'b0;
    chk("abort/busy_wr", {busy, fifo_wr}, 2'b00);
    dat_i = 4'hF;
    repeat (6) cycle();
    chk("abort/no_done", done_cnt, 0);
    chk("abort/nwr", wr_val.size(), 2);
    chk("abort/idle", busy, 1'b0);
    blk_bytes[0] = 8'h12; blk_bytes[1] = 8'h34; blk_bytes[2] = 8'h56; blk_bytes[3] = 8'h78;
    run_block("after_abort", 1'b1, 12'd4, 1'b0, 0, 0, 4'hF, 1, 0, 1'b1, 1'b0, 8);

    // asynchronous reset in the middle of a block
    bus_4bit = 1'b1; blk_len = 12'd4; start_rx = 1'b1; dat_i = 4'hF;
    cycle();
    start_rx = 1'b0;
    dat_i = 4'h0; cycle();
    dat_i = 4'h9; cycle();
    chk("rst_mid/pre", {fifo_wr, fifo_d, busy}, 6'b1_1001_1);
    #2 rst = 1'b1;
    #1 chk("rst_mid/async", {fifo_d, fifo_wr, busy, done, crc_ok, ovf, tout}, 0);
    @(negedge sd_clk);
    rst = 1'b0;
    dat_i = 4'hF;
    cycle();
    chk("rst_mid/idle", busy, 1'b0);

`ifdef SD_RX_TIMEOUT_EN
    timeout = 16'd10; bus_4bit = 1'b1; blk_len = 12'd4; start_rx = 1'b1; dat_i = 4'hF;
    cycle();
    start_rx = 1'b0; cs = cyc;
    clear_obs();
    repeat (14) cycle();
    chk("tmo10/done_cnt", done_cnt, 1);
    chk("tmo10/done_lat", done_cyc - cs, 10);
    chk("tmo10/crc_ok", done_crc, 1'b0);
    chk("tmo10/tout", tout, 1'b1);
    chk("tmo10/busy", busy, 1'b0);
    timeout = 16'd0; start_rx = 1'b1;
    cycle();
    start_rx = 1'b0; cs = cyc;
    chk("tmo0/tout_cleared", tout, 1'b0);
    clear_obs();
    repeat (4) cycle();
    chk("tmo0/done_lat", done_cyc - cs, 1);
    chk("tmo0/tout", tout, 1'b1);
    timeout = 16'hFFFF;
`else
    timeout = 16'd10; bus_4bit = 1'b1; blk_len = 12'd4; start_rx = 1'b1; dat_i = 4'hF;
    cycle();
    start_rx = 1'b0;
    clear_obs();
    repeat (40) cycle();
    chk("notmo/busy", busy, 1'b1);
    chk("notmo/no_done", done_cnt, 0);
    chk("notmo/tout", tout, 1'b0);
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    chk("notmo/abort_idle", busy, 1'b0);
    timeout = 16'hFFFF;
`endif

    // randomized blocks against the model
    for (int r = 0; r < 14; r++) begin
      rb4 = 1'($urandom);
      rbl = 12'($urandom_range(1, 6));
      for (int k = 0; k < 64; k++) blk_bytes[k] = 8'($urandom);
      rfe = ($urandom_range(0, 3) == 0);
      rfl = $urandom_range(0, 3);
      rfb = $urandom_range(0, 15);
      rev = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      if ($urandom_range(0, 2) == 0) begin
        lo = $urandom_range(0, 2 * int'(rbl) - 1);
        hi = lo + $urandom_range(0, 3);
      end else begin
        lo = 1; hi = 0;
      end
      cnt = 0;
      for (int n = 0; n < 2 * int'(rbl); n++) if (n >= lo && n <= hi) cnt++;
      ecrc = !(rfe && (rb4 || rfl == 0)) && (rb4 ? (rev == 4'hF) : rev[0]);
      run_block($sformatf("rnd%0d", r), rb4, rbl, rfe, rfl, rfb, rev, lo, hi,
                ecrc, cnt > 0, 2 * int'(rbl) - cnt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
